ex_flag_stage: RTL

EX/MEM boundary stage placed directly downstream of the 16-bit ALU. It registers the ALU result and destination for the memory stage and maintains the architectural Z/V/N flag register from the ALU flag outputs. It also resolves conditional branches against that flag register and implements a valid/stall/flush handshake with its neighbours.

---
 rtl/ex_flag_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ex_flag_stage.sv
// EX/MEM boundary register: captures ALU result/destination, owns the Z/V/N flag register
// and resolves conditional branches. Optional taken-branch counter behind EX_PERF_CNT_EN.
module ex_flag_stage #(
    parameter int DATA_W = 16,
    parameter int DST_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_z,
    input  logic              ex_v,
    input  logic              ex_n,
    input  logic [2:0]        ex_alu_op,
    input  logic              ex_set_flags,
    input  logic              ex_is_branch,
    input  logic [2:0]        ex_cond,
    input  logic [DST_W-1:0]  ex_dst,
    input  logic              flush,
    input  logic              mem_stall,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DST_W-1:0]  mem_dst,
    output logic              mem_br_taken,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n,
    output logic [15:0]       br_taken_cnt
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    logic              mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0] mem_result_q, mem_result_d;
    logic [DST_W-1:0]  mem_dst_q, mem_dst_d;
    logic              mem_br_taken_q, mem_br_taken_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_v_q, flag_v_d;
    logic              flag_n_q, flag_n_d;
    logic              accept;
    logic              cond_true;
    logic              taken;

    assign ex_ready = ~mem_valid_q | ~mem_stall;
    assign accept   = ex_valid & ex_ready & ~flush;
    assign taken    = ex_is_branch & cond_true;

    // Conditions look at the registered flags, so a flag-setting branch sees the old values.
    always_comb begin
        cond_true = 1'b0;
        case (ex_cond)
            3'b000:  cond_true = ~flag_z_q;
            3'b001:  cond_true = flag_z_q;
            3'b010:  cond_true = ~flag_z_q & ~flag_n_q;
            3'b011:  cond_true = flag_n_q;
            3'b100:  cond_true = ~flag_n_q;
            3'b101:  cond_true = flag_n_q | flag_z_q;
            3'b110:  cond_true = flag_v_q;
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        mem_valid_d    = mem_valid_q;
        mem_result_d   = mem_result_q;
        mem_dst_d      = mem_dst_q;
        mem_br_taken_d = mem_br_taken_q;
        flag_z_d       = flag_z_q;
        flag_v_d       = flag_v_q;
        flag_n_d       = flag_n_q;
        if (accept) begin
            mem_valid_d    = 1'b1;
            mem_result_d   = ex_result;
            mem_dst_d      = ex_dst;
            mem_br_taken_d = taken;
            if (ex_set_flags) begin
                flag_z_d = ex_z;
                // Only arithmetic ops produce meaningful overflow/sign flags.
                if (ex_alu_op == OP_ADD || ex_alu_op == OP_SUB) begin
                    flag_v_d = ex_v;
                    flag_n_d = ex_n;
                end
            end
        end else if (flush) begin
            mem_valid_d    = 1'b0;
            mem_br_taken_d = 1'b0;
        end else if (!mem_stall) begin
            mem_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_q    <= 1'b0;
            mem_result_q   <= '0;
            mem_dst_q      <= '0;
            mem_br_taken_q <= 1'b0;
            flag_z_q       <= 1'b0;
            flag_v_q       <= 1'b0;
            flag_n_q       <= 1'b0;
        end else begin
            mem_valid_q    <= mem_valid_d;
            mem_result_q   <= mem_result_d;
            mem_dst_q      <= mem_dst_d;
            mem_br_taken_q <= mem_br_taken_d;
            flag_z_q       <= flag_z_d;
            flag_v_q       <= flag_v_d;
            flag_n_q       <= flag_n_d;
        end
    end

    assign mem_valid    = mem_valid_q;
    assign mem_result   = mem_result_q;
    assign mem_dst      = mem_dst_q;
    assign mem_br_taken = mem_br_taken_q;
    assign flag_z       = flag_z_q;
    assign flag_v       = flag_v_q;
    assign flag_n       = flag_n_q;

`ifdef EX_PERF_CNT_EN
    logic [15:0] br_cnt_q, br_cnt_d;

    always_comb begin
        br_cnt_d = br_cnt_q;
        if (accept && taken) begin
            br_cnt_d = br_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q <= 16'h0000;
        end else begin
            br_cnt_q <= br_cnt_d;
        end
    end

    assign br_taken_cnt = br_cnt_q;
`else
    assign br_taken_cnt = 16'h0000;
`endif

endmodule
